// File: rtl/rle_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rle_pkg
// Brief    : Shared state encoding, token type and run-length helper.
// Revision : 1.0
// ============================================================================
package rle_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRE_RD   = 3'd1,
        PRE_WAIT = 3'd2,
        RUN      = 3'd3,
        FIN_RD   = 3'd4,
        FIN_WAIT = 3'd5,
        FIN_WR   = 3'd6,
        DONE     = 3'd7
    } rle_state_t;

    localparam int TOK_LEN_W = 8;

    typedef struct packed {
        logic                 val;
        logic [TOK_LEN_W-1:0] len;
    } rle_token_t;

    function automatic logic [31:0] min_run(input logic [31:0] run_left,
                                            input logic [31:0] room);
        return (run_left < room) ? run_left : room;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rle_fill_mask.sv
`default_nettype none
// ============================================================================
// Module   : rle_fill_mask
// Brief    : Mask of n bits starting bit_ptr bits below the word MSB.
// Revision : 1.0
// ============================================================================
module rle_fill_mask
    import rle_pkg::*;
#(
    parameter  int WORD_W = 8,
    localparam int BIT_W  = $clog2(WORD_W)
) (
    input  logic [BIT_W-1:0]  bit_ptr,
    input  logic [BIT_W:0]    n,
    output logic [WORD_W-1:0] mask
);

    localparam logic [WORD_W-1:0] c_ones = '1;

    logic [BIT_W:0] w_end;

    // Shifts of WORD_W or more give zero, so a run ending at the LSB works.
    assign w_end = {1'b0, bit_ptr} + n;
    assign mask  = (c_ones >> bit_ptr) & ~(c_ones >> w_end);

endmodule
`default_nettype wire

// File: rtl/rle_bit_packer.sv
`default_nettype none
// ============================================================================
// Module   : rle_bit_packer
// Brief    : Expands (bit, length) runs and packs them MSB-first into RAM
//            words with read-modify-write of partial words.
//            Optional statistics outputs: define RLE_PACKER_STATS_EN.
// Revision : 1.0
// ============================================================================
module rle_bit_packer
    import rle_pkg::*;
#(
    parameter  int WORD_W = 8,
    parameter  int ADDR_W = 16,
    parameter  int LEN_W  = 8,
    localparam int BIT_W  = $clog2(WORD_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [BIT_W-1:0]  start_bit,
    input  logic              tok_valid,
    output logic              tok_ready,
    input  logic              tok_bit,
    input  logic [LEN_W-1:0]  tok_len,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] end_addr,
    output logic [BIT_W-1:0]  end_bit,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [WORD_W-1:0] mem_rdata
`ifdef RLE_PACKER_STATS_EN
    ,
    output logic [31:0]       stat_tokens,
    output logic [31:0]       stat_words
`endif
);

    localparam logic [BIT_W:0] c_full_ptr = (BIT_W+1)'(WORD_W);

    rle_state_t        r_state, w_state_n;
    logic [WORD_W-1:0] r_acc, w_acc_n;
    logic [BIT_W:0]    r_bit_ptr, w_ptr_n;
    logic [LEN_W-1:0]  r_run_left, w_run_left_n;
    logic              r_run_val, w_run_val_n;
    logic              r_flush, w_flush_n;
    logic [ADDR_W-1:0] r_cur_addr, w_addr_n;

    logic              w_busy_n, w_done_n, w_we_n, w_re_n;
    logic [ADDR_W-1:0] w_mem_addr_n, w_end_addr_n;
    logic [WORD_W-1:0] w_wdata_n;
    logic [BIT_W-1:0]  w_end_bit_n;

    logic              w_accept, w_full;
    logic [BIT_W:0]    w_ptr_eff, w_room, w_n, w_ptr_fill;
    logic [WORD_W-1:0] w_acc_eff, w_acc_fill, w_fill_mask, w_top_mask, w_merged;
    logic [ADDR_W-1:0] w_addr_eff;

    assign tok_ready = (r_state == RUN) && (r_run_left == '0) && !r_flush;
    assign w_accept  = tok_valid && tok_ready;

    // A full word is written out and cleared in the same cycle the next fill
    // step lands, so the fill always works from the "effective" word state.
    assign w_full     = (r_bit_ptr == c_full_ptr);
    assign w_ptr_eff  = w_full ? '0 : r_bit_ptr;
    assign w_acc_eff  = w_full ? '0 : r_acc;
    assign w_addr_eff = w_full ? r_cur_addr + ADDR_W'(1) : r_cur_addr;
    assign w_room     = c_full_ptr - w_ptr_eff;
    assign w_n        = (BIT_W+1)'(min_run(32'(r_run_left), 32'(w_room)));
    assign w_ptr_fill = w_ptr_eff + w_n;

    rle_fill_mask #(.WORD_W(WORD_W)) u_fill_mask (
        .bit_ptr (w_ptr_eff[BIT_W-1:0]),
        .n       (w_n),
        .mask    (w_fill_mask)
    );

    rle_fill_mask #(.WORD_W(WORD_W)) u_top_mask (
        .bit_ptr ({BIT_W{1'b0}}),
        .n       (r_bit_ptr),
        .mask    (w_top_mask)
    );

    assign w_acc_fill = r_run_val ? (w_acc_eff | w_fill_mask) : (w_acc_eff & ~w_fill_mask);
    assign w_merged   = (r_acc & w_top_mask) | (mem_rdata & ~w_top_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_n;
    end

    always_comb begin
        w_state_n    = r_state;
        w_acc_n      = r_acc;
        w_ptr_n      = r_bit_ptr;
        w_run_left_n = r_run_left;
        w_run_val_n  = r_run_val;
        w_flush_n    = r_flush;
        w_addr_n     = r_cur_addr;
        w_we_n       = 1'b0;
        w_wdata_n    = mem_wdata;
        w_mem_addr_n = mem_addr;
        w_end_addr_n = end_addr;
        w_end_bit_n  = end_bit;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_addr_n     = start_addr;
                    w_ptr_n      = {1'b0, start_bit};
                    w_acc_n      = '0;
                    w_run_left_n = '0;
                    w_flush_n    = 1'b0;
                    w_state_n    = (start_bit != '0) ? PRE_RD : RUN;
                end
            end
            PRE_RD: begin
                w_flush_n = r_flush | flush;
                w_state_n = PRE_WAIT;
            end
            PRE_WAIT: begin
                w_flush_n = r_flush | flush;
                w_acc_n   = mem_rdata & w_top_mask;
                w_state_n = RUN;
            end
            RUN: begin
                w_flush_n = r_flush | flush;
                if (w_accept) begin
                    w_run_left_n = tok_len;
                    w_run_val_n  = tok_bit;
                end
                if (w_full) begin
                    w_acc_n  = '0;
                    w_ptr_n  = '0;
                    w_addr_n = w_addr_eff;
                end
                if (r_run_left != '0) begin
                    w_acc_n      = w_acc_fill;
                    w_ptr_n      = w_ptr_fill;
                    w_run_left_n = r_run_left - LEN_W'(w_n);
                    w_addr_n     = w_addr_eff;
                    if (w_ptr_fill == c_full_ptr) begin
                        w_we_n       = 1'b1;
                        w_wdata_n    = w_acc_fill;
                        w_mem_addr_n = w_addr_eff;
                    end
                end else if (r_flush && !w_full) begin
                    w_state_n = (r_bit_ptr == '0) ? DONE : FIN_RD;
                end
            end
            FIN_RD:   w_state_n = FIN_WAIT;
            FIN_WAIT: begin
                w_acc_n      = w_merged;
                w_we_n       = 1'b1;
                w_wdata_n    = w_merged;
                w_mem_addr_n = r_cur_addr;
                w_state_n    = FIN_WR;
            end
            FIN_WR:   w_state_n = DONE;
            DONE:     w_state_n = IDLE;
            default:  w_state_n = IDLE;
        endcase

        // Registered outputs follow the state being entered.
        w_re_n   = (w_state_n == PRE_RD) || (w_state_n == FIN_RD);
        w_done_n = (w_state_n == DONE);
        w_busy_n = (w_state_n != IDLE) && (w_state_n != DONE);
        if (w_re_n) w_mem_addr_n = w_addr_n;
        if (w_done_n) begin
            w_end_addr_n = r_cur_addr;
            w_end_bit_n  = r_bit_ptr[BIT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_bit_ptr  <= '0;
            r_run_left <= '0;
            r_run_val  <= 1'b0;
            r_flush    <= 1'b0;
            r_cur_addr <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            end_addr   <= '0;
            end_bit    <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
        end else begin
            r_acc      <= w_acc_n;
            r_bit_ptr  <= w_ptr_n;
            r_run_left <= w_run_left_n;
            r_run_val  <= w_run_val_n;
            r_flush    <= w_flush_n;
            r_cur_addr <= w_addr_n;
            busy       <= w_busy_n;
            done       <= w_done_n;
            end_addr   <= w_end_addr_n;
            end_bit    <= w_end_bit_n;
            mem_addr   <= w_mem_addr_n;
            mem_wdata  <= w_wdata_n;
            mem_we     <= w_we_n;
            mem_re     <= w_re_n;
        end
    end

`ifdef RLE_PACKER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_tokens <= '0;
            stat_words  <= '0;
        end else if (r_state == IDLE && start) begin
            stat_tokens <= '0;
            stat_words  <= '0;
        end else begin
            if (w_accept && tok_len != '0 && stat_tokens != '1)
                stat_tokens <= stat_tokens + 32'd1;
            if (w_we_n && stat_words != '1)
                stat_words <= stat_words + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rle_bit_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rle_bit_packer
// Brief    : Scoreboard bench for rle_bit_packer with a behavioural RAM.
// Revision : 1.0
// ============================================================================
module tb_rle_bit_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] start_addr = '0;
    logic [2:0]  start_bit = '0;
    logic        tok_valid = 1'b0;
    logic        tok_ready;
    logic        tok_bit = 1'b0;
    logic [7:0]  tok_len = '0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [15:0] end_addr;
    logic [2:0]  end_bit;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we, mem_re;
    logic [7:0]  mem_rdata = '0;
`ifdef RLE_PACKER_STATS_EN
    logic [31:0] stat_tokens, stat_words;
`endif

    rle_bit_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .start_bit  (start_bit),
        .tok_valid  (tok_valid),
        .tok_ready  (tok_ready),
        .tok_bit    (tok_bit),
        .tok_len    (tok_len),
        .flush      (flush),
        .busy       (busy),
        .done       (done),
        .end_addr   (end_addr),
        .end_bit    (end_bit),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata)
`ifdef RLE_PACKER_STATS_EN
        ,
        .stat_tokens(stat_tokens),
        .stat_words (stat_words)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem[mem_addr];
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int n_wr     = 0;
    int n_done   = 0;
    int cyc      = 0;
    bit sb_on    = 1'b1;
    logic [23:0] exp_wr[$];
    logic [15:0] exp_rd[$];
    int          wr_cyc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [23:0] e;
        logic [15:0] ra;
        cyc = cyc + 1;
        if (done) n_done++;
        if (mem_we) begin
            n_wr++;
            wr_cyc.push_back(cyc);
            if (sb_on) begin
                if (exp_wr.size() == 0) begin
                    check("wr_unexpected", {mem_addr, 8'h00, mem_wdata}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_wr.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(e[23:8]));
                    check("wr_data", 32'(mem_wdata), 32'(e[7:0]));
                end
            end
        end
        if (mem_re && sb_on) begin
            if (exp_rd.size() == 0) begin
                check("rd_unexpected", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
                ra = exp_rd.pop_front();
                check("rd_addr", 32'(mem_addr), 32'(ra));
            end
        end
    end

    task automatic preload(input logic [15:0] a, input logic [7:0] v);
        mem[a] <= v;
    endtask

    task automatic do_start(input logic [15:0] a, input logic [2:0] b);
        @(negedge clk);
        start_addr = a;
        start_bit  = b;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic send_tok(input logic b, input logic [7:0] l, input logic f);
        int i;
        for (i = 0; i < 300; i++) begin
            if (tok_ready) break;
            @(negedge clk);
        end
        if (i == 300) check("tok_ready_timeout", 32'(tok_ready), 32'd1);
        tok_valid = 1'b1;
        tok_bit   = b;
        tok_len   = l;
        flush     = f;
        @(negedge clk);
        tok_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic [15:0] ea, input logic [2:0] eb);
        int i;
        for (i = 0; i < 300; i++) begin
            if (done) break;
            @(negedge clk);
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_end_addr"}, 32'(end_addr), 32'(ea));
        check({tag, "_end_bit"}, 32'(end_bit), 32'(eb));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_wr_left"}, 32'(exp_wr.size()), 32'd0);
        check({tag, "_rd_left"}, 32'(exp_rd.size()), 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int wr0, dn0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_tok_ready", 32'(tok_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_re", 32'(mem_re), 32'd0);
        check("rst_ends", {end_addr, 13'd0, end_bit}, 32'd0);
        check("rst_mem_bus", {mem_addr, 8'd0, mem_wdata}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Aligned full words
        exp_wr.push_back({16'h0010, 8'hE0});
        exp_wr.push_back({16'h0011, 8'hFF});
        do_start(16'h0010, 3'd0);
        check("s1_busy", 32'(busy), 32'd1);
        send_tok(1'b1, 8'd3, 1'b0);
        send_tok(1'b0, 8'd5, 1'b0);
        send_tok(1'b1, 8'd8, 1'b0);
        do_flush();
        wait_done("s1", 16'h0012, 3'd0);
`ifdef RLE_PACKER_STATS_EN
        check("stat_tokens", stat_tokens, 32'd3);
        check("stat_words", stat_words, 32'd2);
`endif

        // Offset preload
        preload(16'h0020, 8'hA5);
        exp_rd.push_back(16'h0020);
        exp_wr.push_back({16'h0020, 8'hA7});
        do_start(16'h0020, 3'd3);
`ifdef RLE_PACKER_STATS_EN
        check("stat_tokens_clr", stat_tokens, 32'd0);
        check("stat_words_clr", stat_words, 32'd0);
`endif
        send_tok(1'b0, 8'd2, 1'b0);
        send_tok(1'b1, 8'd3, 1'b0);
        do_flush();
        wait_done("s2", 16'h0021, 3'd0);

        // Partial last word
        preload(16'h0030, 8'h0F);
        exp_rd.push_back(16'h0030);
        exp_wr.push_back({16'h0030, 8'hEF});
        do_start(16'h0030, 3'd0);
        send_tok(1'b1, 8'd3, 1'b0);
        do_flush();
        wait_done("s3", 16'h0030, 3'd3);

        // Long run with backpressure
        preload(16'h0072, 8'h5A);
        exp_wr.push_back({16'h0070, 8'hFF});
        exp_wr.push_back({16'h0071, 8'hFF});
        exp_rd.push_back(16'h0072);
        exp_wr.push_back({16'h0072, 8'hFA});
        wr_cyc.delete();
        do_start(16'h0070, 3'd0);
        send_tok(1'b1, 8'd20, 1'b0);
        check("s4_backpressure", 32'(tok_ready), 32'd0);
        do_flush();
        wait_done("s4", 16'h0072, 3'd4);
        check("s4_consecutive", 32'(wr_cyc[1] - wr_cyc[0]), 32'd1);

        // Empty run
        wr0 = n_wr;
        do_start(16'h0050, 3'd0);
        send_tok(1'b1, 8'd0, 1'b0);
        do_flush();
        wait_done("s5_len0", 16'h0050, 3'd0);
        check("s5_len0_no_write", 32'(n_wr - wr0), 32'd0);

        // Address wrap
        preload(16'h0000, 8'h33);
        exp_wr.push_back({16'hFFFF, 8'hFF});
        exp_rd.push_back(16'h0000);
        exp_wr.push_back({16'h0000, 8'hF3});
        do_start(16'hFFFF, 3'd0);
        send_tok(1'b1, 8'd12, 1'b0);
        do_flush();
        wait_done("s5_wrap", 16'h0000, 3'd4);

        // Flush together with a token
        preload(16'h0061, 8'h15);
        exp_wr.push_back({16'h0060, 8'hFF});
        exp_rd.push_back(16'h0061);
        exp_wr.push_back({16'h0061, 8'hD5});
        do_start(16'h0060, 3'd0);
        send_tok(1'b1, 8'd10, 1'b1);
        wait_done("s5_flush_tok", 16'h0061, 3'd2);

        // Reset mid-run
        sb_on = 1'b0;
        do_start(16'h0040, 3'd0);
        send_tok(1'b1, 8'd200, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_we", 32'(mem_we), 32'd0);
        check("mid_rst_re", 32'(mem_re), 32'd0);
        check("mid_rst_tok_ready", 32'(tok_ready), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        wr0 = n_wr;
        dn0 = n_done;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_writes", 32'(n_wr - wr0), 32'd0);
        check("post_rst_done", 32'(n_done - dn0), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
